// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
// -------------
// Program-counter sequencer and instruction-fetch controller at the front of
// the pipeline. It owns the PC, keeps at most one request open towards
// instruction memory and hands each fetched word to decode. Redirects from
// execute are turned into a target address here from the NPCOp code.
//
// Ports
//   clk, rst         clock (rising edge) and asynchronous active-high reset
//   imem_req         fetch request, high only in FETCH and DRAIN
//   imem_addr        fetch address, always equal to the PC register
//   imem_ack         memory returned data this cycle (may come with req's rise)
//   imem_rdata       instruction word, valid with imem_ack
//   if_valid         if_pc / if_instr hold an instruction for decode
//   if_pc, if_instr  presented PC and instruction word
//   if_ready         decode accepts the presented instruction
//   redirect_valid   one-cycle redirect pulse from execute
//   redirect_op      NPCOp code selecting how the target is formed
//   redirect_pc      PC of the redirecting instruction
//   redirect_imm     26-bit immediate field of that instruction
//   redirect_rd      register operand used by JR / JALR
//   fetch_err        sticky flag: a redirect target was not word aligned
//   dbg_state        current FSM state (see state_e encoding)
//
// Decode handshake: an instruction moves to decode in a cycle where
// if_valid=1 and if_ready=1 at the rising edge. Once if_valid is high,
// if_pc and if_instr do not change until that transfer happens or a
// redirect flushes the slot; if_valid never depends on if_ready
// combinationally.
//
// NPCOp encoding used on redirect_op:
//   0 PLUS4, 1 BRANCH, 2 JUMP, 3 JR, 4 JALR; any other code behaves as PLUS4.

module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready,
  input  logic        redirect_valid,
  input  logic [3:0]  redirect_op,
  input  logic [31:0] redirect_pc,
  input  logic [25:0] redirect_imm,
  input  logic [31:0] redirect_rd,
  output logic        fetch_err,
  output logic [2:0]  dbg_state
);

  localparam logic [3:0] NPC_PLUS4  = 4'd0;
  localparam logic [3:0] NPC_BRANCH = 4'd1;
  localparam logic [3:0] NPC_JUMP   = 4'd2;
  localparam logic [3:0] NPC_JR     = 4'd3;
  localparam logic [3:0] NPC_JALR   = 4'd4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_HOLD  = 3'd2,
    S_DRAIN = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        err_pend_q, err_pend_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        fetch_err_q, fetch_err_d;

  // ---------------------------------------------------------------------
  // Redirect target
  // ---------------------------------------------------------------------
  logic [31:0] redir_p4;
  logic [31:0] redir_br_off;
  logic [31:0] redir_tgt;
  logic        redir_misaligned;

  assign redir_p4     = redirect_pc + 32'd4;
  // Branch offset: 16-bit word offset, sign extended and scaled to bytes.
  assign redir_br_off = {{14{redirect_imm[15]}}, redirect_imm[15:0], 2'b00};

  always_comb begin
    redir_tgt = redir_p4;
    case (redirect_op)
      NPC_PLUS4:  redir_tgt = redir_p4;
      NPC_BRANCH: redir_tgt = redir_p4 + redir_br_off;
      NPC_JUMP:   redir_tgt = {redir_p4[31:28], redirect_imm, 2'b00};
      NPC_JR:     redir_tgt = redirect_rd;
      NPC_JALR:   redir_tgt = redirect_rd;
      default:    redir_tgt = redir_p4;
    endcase
  end

  assign redir_misaligned = |redir_tgt[1:0];

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      pend_pc_q   <= RESET_PC;
      err_pend_q  <= 1'b0;
      if_valid_q  <= 1'b0;
      if_pc_q     <= 32'd0;
      if_instr_q  <= 32'd0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_pc_q   <= pend_pc_d;
      err_pend_q  <= err_pend_d;
      if_valid_q  <= if_valid_d;
      if_pc_q     <= if_pc_d;
      if_instr_q  <= if_instr_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic. A redirect outranks every other event in a state.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_pc_d   = pend_pc_q;
    err_pend_d  = err_pend_q;
    if_valid_d  = if_valid_q;
    if_pc_d     = if_pc_q;
    if_instr_d  = if_instr_q;
    fetch_err_d = fetch_err_q;

    case (state_q)
      S_IDLE: begin
        if (redirect_valid) begin
          if_valid_d = 1'b0;
          if (redir_misaligned) begin
            fetch_err_d = 1'b1;
            state_d     = S_ERR;
          end else begin
            pc_d    = redir_tgt;
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        if (redirect_valid) begin
          if_valid_d = 1'b0;
          if (redir_misaligned) begin
            fetch_err_d = 1'b1;
            // With the request still open it must finish before parking.
            if (imem_ack) begin
              state_d = S_ERR;
            end else begin
              err_pend_d = 1'b1;
              state_d    = S_DRAIN;
            end
          end else if (imem_ack) begin
            // Returned word is wrong-path; the request is closed, so the
            // PC can move now and the next cycle fetches the target.
            pc_d    = redir_tgt;
            state_d = S_FETCH;
          end else begin
            // imem_addr must stay put until ack: park the target.
            pend_pc_d = redir_tgt;
            state_d   = S_DRAIN;
          end
        end else if (imem_ack) begin
          if_instr_d = imem_rdata;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          pc_d       = pc_q + 32'd4;
          state_d    = S_HOLD;
        end
      end

      S_HOLD: begin
        if (redirect_valid) begin
          // A transfer in this same cycle is squashed by decode.
          if_valid_d = 1'b0;
          if (redir_misaligned) begin
            fetch_err_d = 1'b1;
            state_d     = S_ERR;
          end else begin
            pc_d    = redir_tgt;
            state_d = S_FETCH;
          end
        end else if (if_valid_q && if_ready) begin
          if_valid_d = 1'b0;
          state_d    = S_FETCH;
        end
      end

      S_DRAIN: begin
        if (redirect_valid) begin
          if_valid_d = 1'b0;
          if (redir_misaligned) begin
            fetch_err_d = 1'b1;
            if (imem_ack) begin
              state_d = S_ERR;
            end else begin
              err_pend_d = 1'b1;
            end
          end else begin
            // Latest redirect wins.
            pend_pc_d = redir_tgt;
            if (imem_ack) begin
              if (err_pend_q) begin
                state_d = S_ERR;
              end else begin
                pc_d    = redir_tgt;
                state_d = S_FETCH;
              end
            end
          end
        end else if (imem_ack) begin
          if (err_pend_q) begin
            state_d = S_ERR;
          end else begin
            pc_d    = pend_pc_q;
            state_d = S_FETCH;
          end
        end
      end

      S_ERR: begin
        // Terminal until reset; redirects are ignored.
        if_valid_d  = 1'b0;
        fetch_err_d = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign imem_req  = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign imem_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;
  assign fetch_err = fetch_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl. A negedge process models instruction memory with
// a programmable number of wait states and acts as the scoreboard: every new
// request address is popped against exp_addr_q, every decode transfer against
// exp_tr_q. Scenario tasks push what the DUT should do and add inline
// cycle-by-cycle checks.

module tb_pc_fetch_ctrl;

  localparam logic [3:0] OP_PLUS4  = 4'd0;
  localparam logic [3:0] OP_BRANCH = 4'd1;
  localparam logic [3:0] OP_JUMP   = 4'd2;
  localparam logic [3:0] OP_JR     = 4'd3;
  localparam logic [3:0] OP_JALR   = 4'd4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HOLD  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;
  logic        redirect_valid;
  logic [3:0]  redirect_op;
  logic [31:0] redirect_pc;
  logic [25:0] redirect_imm;
  logic [31:0] redirect_rd;
  logic        fetch_err;
  logic [2:0]  dbg_state;

  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_tr_q[$];
  int          vectors;
  int          miscompares;
  int          mem_lat;
  int          wait_cnt;
  bit          req_prev;
  logic [31:0] addr_prev;

  pc_fetch_ctrl #(.RESET_PC(32'h0000_3000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_ready       (if_ready),
    .redirect_valid (redirect_valid),
    .redirect_op    (redirect_op),
    .redirect_pc    (redirect_pc),
    .redirect_imm   (redirect_imm),
    .redirect_rd    (redirect_rd),
    .fetch_err      (fetch_err),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return ~a ^ 32'h1357_9BDF;
  endfunction

  // ---------------- memory model + scoreboard ----------------
  always @(negedge clk) begin : mem_and_sb
    logic [31:0] ea;
    logic [63:0] et;
    if (rst) begin
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      wait_cnt   = 0;
      req_prev   = 1'b0;
      addr_prev  = 32'd0;
    end else begin
      // imem_ack still holds the value seen at the edge just passed.
      if (imem_req && (!req_prev || imem_ack)) begin
        vectors++;
        if (exp_addr_q.size() == 0) begin
          miscompares++;
          $display("FAIL req_addr: got request at %h, expected no request", imem_addr);
        end else begin
          ea = exp_addr_q.pop_front();
          if (imem_addr !== ea) begin
            miscompares++;
            $display("FAIL req_addr: got %h, expected %h", imem_addr, ea);
          end
        end
      end else if (imem_req && req_prev) begin
        vectors++;
        if (imem_addr !== addr_prev) begin
          miscompares++;
          $display("FAIL req_stable: got %h, expected %h", imem_addr, addr_prev);
        end
      end else if (!imem_req && req_prev && !imem_ack) begin
        vectors++;
        miscompares++;
        $display("FAIL req_dropped: got req 0 at %h, expected 1 until ack", addr_prev);
      end
      if (if_valid && if_ready && !redirect_valid) begin
        vectors++;
        if (exp_tr_q.size() == 0) begin
          miscompares++;
          $display("FAIL transfer: got pc %h instr %h, expected no transfer", if_pc, if_instr);
        end else begin
          et = exp_tr_q.pop_front();
          if ({if_pc, if_instr} !== et) begin
            miscompares++;
            $display("FAIL transfer: got %h/%h, expected %h/%h", if_pc, if_instr, et[63:32], et[31:0]);
          end
        end
      end
      req_prev  = imem_req;
      addr_prev = imem_addr;
      if (imem_req) begin
        if (wait_cnt >= mem_lat) begin
          imem_ack   = 1'b1;
          imem_rdata = instr_of(imem_addr);
          wait_cnt   = 0;
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = 32'hDEAD_BEEF;
          wait_cnt++;
        end
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        wait_cnt   = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Returns at the start of the first cycle after reset (state IDLE).
  task automatic apply_reset(input int lat);
    @(posedge clk); #1;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_op    = OP_PLUS4;
    redirect_pc    = 32'd0;
    redirect_imm   = 26'd0;
    redirect_rd    = 32'd0;
    if_ready       = 1'b0;
    mem_lat        = lat;
    exp_addr_q.delete();
    exp_tr_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drive_redirect(input bit v, input logic [3:0] op, input logic [31:0] pc,
                                input logic [25:0] imm, input logic [31:0] rd);
    redirect_valid = v;
    redirect_op    = op;
    redirect_pc    = pc;
    redirect_imm   = imm;
    redirect_rd    = rd;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    redirect_valid = 1'b0; redirect_op = OP_PLUS4; redirect_pc = 32'd0;
    redirect_imm = 26'd0; redirect_rd = 32'd0; if_ready = 1'b0; mem_lat = 1000;
    @(negedge clk);
    vectors++;
    if ({imem_req, imem_addr, if_valid, if_pc, if_instr, fetch_err, dbg_state} !==
        {1'b0, 32'h3000, 1'b0, 32'd0, 32'd0, 1'b0, ST_IDLE}) begin
      miscompares++;
      $display("FAIL reset_values: got req %b addr %h v %b pc %h instr %h err %b st %0d, expected 0 3000 0 0 0 0 0",
               imem_req, imem_addr, if_valid, if_pc, if_instr, fetch_err, dbg_state);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_addr_q.push_back(32'h3000);
    @(posedge clk); #1;  // cycle 1: FETCH, memory stalls
    @(negedge clk);
    vectors++;
    if (imem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL first_req: got %b, expected 1", imem_req);
    end
    @(posedge clk); #1;
    rst = 1'b1;  // abandon the open request
    #1;
    vectors++;
    if ({imem_req, dbg_state, imem_addr} !== {1'b0, ST_IDLE, 32'h3000}) begin
      miscompares++;
      $display("FAIL reset_mid_req: got req %b st %0d addr %h, expected 0 0 3000", imem_req, dbg_state, imem_addr);
    end
  endtask

  task automatic test_stream();
    bit [8:0] exp_req = 9'b010101010;
    bit [8:0] exp_val = 9'b101010100;
    apply_reset(0);
    foreach (exp_addr_q[i]) exp_addr_q.delete(i);
    exp_addr_q = '{32'h3000, 32'h3004, 32'h3008, 32'h300C};
    for (int i = 0; i < 3; i++) exp_tr_q.push_back({32'h3000 + 32'(4 * i), instr_of(32'h3000 + 32'(4 * i))});
    for (int k = 0; k < 9; k++) begin
      if_ready = (k < 8);
      @(negedge clk);
      vectors++;
      if ({imem_req, if_valid} !== {exp_req[k], exp_val[k]}) begin
        miscompares++;
        $display("FAIL stream_c%0d: got req/valid %b%b, expected %b%b", k, imem_req, if_valid, exp_req[k], exp_val[k]);
      end
      @(posedge clk); #1;
    end
    vectors++;
    if ({if_pc, if_instr} !== {32'h300C, instr_of(32'h300C)}) begin
      miscompares++;
      $display("FAIL stream_hold: got %h/%h, expected 0000300c/%h", if_pc, if_instr, instr_of(32'h300C));
    end
    vectors++;
    if (exp_addr_q.size() != 0 || exp_tr_q.size() != 0) begin
      miscompares++;
      $display("FAIL stream_left: got %0d/%0d pending, expected 0/0", exp_addr_q.size(), exp_tr_q.size());
    end
  endtask

  task automatic test_wait_states();
    bit [8:0] exp_req = 9'b011101110;
    bit [8:0] exp_val = 9'b100010000;
    apply_reset(2);
    exp_addr_q = '{32'h3000, 32'h3004};
    exp_tr_q.push_back({32'h3000, instr_of(32'h3000)});
    for (int k = 0; k < 9; k++) begin
      if_ready = (k < 8);
      @(negedge clk);
      vectors++;
      if ({imem_req, if_valid} !== {exp_req[k], exp_val[k]}) begin
        miscompares++;
        $display("FAIL wait_c%0d: got req/valid %b%b, expected %b%b", k, imem_req, if_valid, exp_req[k], exp_val[k]);
      end
      if (k >= 5 && k <= 7) begin
        vectors++;
        if (imem_addr !== 32'h3004) begin
          miscompares++;
          $display("FAIL wait_addr_c%0d: got %h, expected 00003004", k, imem_addr);
        end
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (exp_addr_q.size() != 0 || exp_tr_q.size() != 0) begin
      miscompares++;
      $display("FAIL wait_left: got %0d/%0d pending, expected 0/0", exp_addr_q.size(), exp_tr_q.size());
    end
  endtask

  task automatic test_hold_stall();
    apply_reset(0);
    exp_addr_q = '{32'h3000, 32'h3004, 32'h3008};
    exp_tr_q.push_back({32'h3000, instr_of(32'h3000)});
    exp_tr_q.push_back({32'h3004, instr_of(32'h3004)});
    for (int k = 0; k < 11; k++) begin
      if_ready = (k < 4) || (k == 8);
      @(negedge clk);
      if (k >= 4 && k <= 7) begin
        vectors++;
        if ({imem_req, if_valid, if_pc, if_instr} !== {1'b0, 1'b1, 32'h3004, instr_of(32'h3004)}) begin
          miscompares++;
          $display("FAIL hold_c%0d: got req %b v %b %h/%h, expected 0 1 00003004/%h",
                   k, imem_req, if_valid, if_pc, if_instr, instr_of(32'h3004));
        end
      end
      if (k == 9) begin
        vectors++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h3008}) begin
          miscompares++;
          $display("FAIL hold_resume: got req %b addr %h, expected 1 00003008", imem_req, imem_addr);
        end
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (exp_addr_q.size() != 0 || exp_tr_q.size() != 0) begin
      miscompares++;
      $display("FAIL hold_left: got %0d/%0d pending, expected 0/0", exp_addr_q.size(), exp_tr_q.size());
    end
  endtask

  task automatic test_branch_drain();
    apply_reset(3);
    exp_addr_q = '{32'h3000, 32'h3004};
    for (int k = 0; k < 10; k++) begin
      drive_redirect(k == 2, OP_BRANCH, 32'h3010, 26'h000FFFC, 32'd0);
      @(negedge clk);
      if (k <= 8) begin
        vectors++;
        if (if_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL branch_valid_c%0d: got %b, expected 0", k, if_valid);
        end
      end
      if (k == 3) begin
        vectors++;
        if ({dbg_state, imem_req, imem_addr} !== {ST_DRAIN, 1'b1, 32'h3000}) begin
          miscompares++;
          $display("FAIL branch_drain: got st %0d req %b addr %h, expected 3 1 00003000", dbg_state, imem_req, imem_addr);
        end
      end
      if (k == 9) begin
        vectors++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h3004, instr_of(32'h3004)}) begin
          miscompares++;
          $display("FAIL branch_target: got v %b %h/%h, expected 1 00003004/%h", if_valid, if_pc, if_instr, instr_of(32'h3004));
        end
      end
      @(posedge clk); #1;
    end
    redirect_valid = 1'b0;
    vectors++;
    if (exp_addr_q.size() != 0 || exp_tr_q.size() != 0) begin
      miscompares++;
      $display("FAIL branch_left: got %0d/%0d pending, expected 0/0", exp_addr_q.size(), exp_tr_q.size());
    end
  endtask

  task automatic test_misaligned_jr();
    apply_reset(0);
    exp_addr_q = '{32'h3000};
    for (int k = 0; k < 8; k++) begin
      if (k == 3)      drive_redirect(1'b1, OP_JR, 32'h3000, 26'd0, 32'h4002);
      else if (k == 5) drive_redirect(1'b1, OP_JUMP, 32'h3000, 26'h0000200, 32'd0);
      else             drive_redirect(1'b0, OP_PLUS4, 32'd0, 26'd0, 32'd0);
      @(negedge clk);
      if (k == 2) begin
        vectors++;
        if ({if_valid, fetch_err} !== 2'b10) begin
          miscompares++;
          $display("FAIL jr_before: got v %b err %b, expected 1 0", if_valid, fetch_err);
        end
      end
      if (k >= 4) begin
        vectors++;
        if ({if_valid, fetch_err, imem_req, dbg_state} !== {1'b0, 1'b1, 1'b0, ST_ERR}) begin
          miscompares++;
          $display("FAIL jr_err_c%0d: got v %b err %b req %b st %0d, expected 0 1 0 4",
                   k, if_valid, fetch_err, imem_req, dbg_state);
        end
      end
      @(posedge clk); #1;
    end
    redirect_valid = 1'b0;
    vectors++;
    if (exp_addr_q.size() != 0 || exp_tr_q.size() != 0) begin
      miscompares++;
      $display("FAIL jr_left: got %0d/%0d pending, expected 0/0", exp_addr_q.size(), exp_tr_q.size());
    end
    apply_reset(0);
    exp_addr_q = '{32'h3000};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) begin
        vectors++;
        if (fetch_err !== 1'b0) begin
          miscompares++;
          $display("FAIL jr_err_clear: got %b, expected 0", fetch_err);
        end
      end
      if (k == 1) begin
        vectors++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h3000}) begin
          miscompares++;
          $display("FAIL jr_resume: got req %b addr %h, expected 1 00003000", imem_req, imem_addr);
        end
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (exp_addr_q.size() != 0) begin
      miscompares++;
      $display("FAIL jr_resume_left: got %0d pending, expected 0", exp_addr_q.size());
    end
  endtask

  task automatic test_back_to_back();
    apply_reset(4);
    exp_addr_q = '{32'h0000_0400, 32'h0000_5000};
    for (int k = 0; k < 12; k++) begin
      if (k == 0)      drive_redirect(1'b1, OP_JUMP, 32'h3000, 26'h0000100, 32'd0);
      else if (k == 2) drive_redirect(1'b1, OP_BRANCH, 32'h0400, 26'h0000010, 32'd0);
      else if (k == 3) drive_redirect(1'b1, OP_JR, 32'h0444, 26'd0, 32'h5000);
      else             drive_redirect(1'b0, OP_PLUS4, 32'd0, 26'd0, 32'd0);
      @(negedge clk);
      if (k == 1) begin
        vectors++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0400}) begin
          miscompares++;
          $display("FAIL jump_target: got req %b addr %h, expected 1 00000400", imem_req, imem_addr);
        end
      end
      if (k == 6) begin
        vectors++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h5000}) begin
          miscompares++;
          $display("FAIL b2b_latest: got req %b addr %h, expected 1 00005000", imem_req, imem_addr);
        end
      end
      if (k == 11) begin
        vectors++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h5000, instr_of(32'h5000)}) begin
          miscompares++;
          $display("FAIL b2b_present: got v %b %h/%h, expected 1 00005000/%h", if_valid, if_pc, if_instr, instr_of(32'h5000));
        end
      end
      @(posedge clk); #1;
    end
    redirect_valid = 1'b0;
    vectors++;
    if (exp_addr_q.size() != 0 || exp_tr_q.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_left: got %0d/%0d pending, expected 0/0", exp_addr_q.size(), exp_tr_q.size());
    end
  endtask

  task automatic test_ack_redirect_wrap();
    apply_reset(0);
    exp_addr_q = '{32'h3000, 32'hFFFF_FFFC, 32'h0000_0000};
    exp_tr_q.push_back({32'hFFFF_FFFC, instr_of(32'hFFFF_FFFC)});
    for (int k = 0; k < 6; k++) begin
      if_ready = (k == 3);
      drive_redirect(k == 1, OP_JALR, 32'h3000, 26'd0, 32'hFFFF_FFFC);
      @(negedge clk);
      if (k == 2) begin
        vectors++;
        if ({if_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'hFFFF_FFFC}) begin
          miscompares++;
          $display("FAIL ackredir_fetch: got v %b req %b addr %h, expected 0 1 fffffffc", if_valid, imem_req, imem_addr);
        end
      end
      if (k == 5) begin
        vectors++;
        if ({if_valid, if_pc, fetch_err, dbg_state} !== {1'b1, 32'd0, 1'b0, ST_HOLD}) begin
          miscompares++;
          $display("FAIL wrap: got v %b pc %h err %b st %0d, expected 1 00000000 0 2", if_valid, if_pc, fetch_err, dbg_state);
        end
      end
      @(posedge clk); #1;
    end
    redirect_valid = 1'b0;
    if_ready = 1'b0;
    vectors++;
    if (exp_addr_q.size() != 0 || exp_tr_q.size() != 0) begin
      miscompares++;
      $display("FAIL wrap_left: got %0d/%0d pending, expected 0/0", exp_addr_q.size(), exp_tr_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    mem_lat     = 0;
    test_reset();
    test_stream();
    test_wait_states();
    test_hold_stall();
    test_branch_drain();
    test_misaligned_jr();
    test_back_to_back();
    test_ack_redirect_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
